// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
//
// Parametrised integer register file with a per-register pending-write
// scoreboard. Each register keeps a saturating count of issued writes that
// have not yet been written back. Issue is held off while the destination
// count is saturated. Reads report a busy flag so decode can stall.
// Writeback data can optionally be forwarded to the read ports in the same
// cycle. Flush clears every pending count but leaves register contents as
// they are. x0 always reads zero and never becomes pending.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   rd_addr      NRD read addresses, port i at [i*AW +: AW]
//   rd_data      NRD read data words, combinational
//   rd_busy      per port: the register still has an unsatisfied pending write
//   issue_valid  decode allocates a pending write to issue_rd
//   issue_rd     destination of the issuing instruction
//   issue_ready  issue accepted this cycle
//   wb_valid     writeback strobe
//   wb_rd        writeback destination
//   wb_data      writeback data
//   flush        clear every pending count
//   sb_err       sticky: writeback hit a register with no pending write
//   dbg_addr     debug read address
//   dbg_data     raw array contents at dbg_addr, never bypassed
// -----------------------------------------------------------------------------
module regfile_sb #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NRD      = 2,
   parameter int MAX_PEND = 3,
   parameter int BYPASS   = 1,
   localparam int AW      = $clog2(NREGS),
   localparam int CW      = $clog2(MAX_PEND + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                issue_valid,
   input  logic [AW-1:0]       issue_rd,
   output logic                issue_ready,
   input  logic                wb_valid,
   input  logic [AW-1:0]       wb_rd,
   input  logic [XLEN-1:0]     wb_data,
   input  logic                flush,
   output logic                sb_err,
   input  logic [AW-1:0]       dbg_addr,
   output logic [XLEN-1:0]     dbg_data
);

   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PEND);

   // Entry 0 is held at zero by reset and never written, so variable-index
   // reads of x0 naturally return a zero value and a zero count.
   logic [XLEN-1:0] regs_reg [NREGS];
   logic [CW-1:0]   cnt_reg  [NREGS];
   logic            sb_err_reg;

   logic wb_fire;
   logic issue_fire;
   logic wb_same_dest;
   logic [NREGS-1:1] issue_hit;
   logic [NREGS-1:1] wb_hit;

   assign wb_fire      = wb_valid && (wb_rd != '0);
   assign wb_same_dest = wb_fire && (wb_rd == issue_rd);

   // A saturated destination can still accept an issue when a writeback to
   // the same register frees a slot in the same cycle.
   assign issue_ready = !flush &&
                        ((issue_rd == '0) || (cnt_reg[issue_rd] != MAX_CNT) || wb_same_dest);
   assign issue_fire  = issue_valid && issue_ready;

   generate
      for (genvar gi = 1; gi < NREGS; gi++) begin : g_hit
         assign issue_hit[gi] = issue_fire && (issue_rd == AW'(gi));
         assign wb_hit[gi]    = wb_fire && (wb_rd == AW'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_reg[i] <= '0;
            cnt_reg[i]  <= '0;
         end
         sb_err_reg <= 1'b0;
      end else begin
         for (int i = 1; i < NREGS; i++) begin
            if (wb_hit[i]) begin
               regs_reg[i] <= wb_data;
            end
            if (flush) begin
               cnt_reg[i] <= '0;
            end else if (issue_hit[i] && !wb_hit[i]) begin
               cnt_reg[i] <= cnt_reg[i] + CW'(1);
            end else if (wb_hit[i] && !issue_hit[i] && (cnt_reg[i] != '0)) begin
               cnt_reg[i] <= cnt_reg[i] - CW'(1);
            end
         end
         // A flush overrides the count effect of a same-cycle writeback,
         // including the error it would otherwise raise.
         if (wb_fire && !flush && (cnt_reg[wb_rd] == '0)) begin
            sb_err_reg <= 1'b1;
         end
      end
   end

   assign sb_err   = sb_err_reg;
   assign dbg_data = regs_reg[dbg_addr];

   generate
      for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
         logic [AW-1:0]   addr;
         logic [XLEN-1:0] data;
         logic            busy;

         assign addr = rd_addr[gi*AW +: AW];

         always_comb begin
            data = regs_reg[addr];
            busy = (cnt_reg[addr] != '0);
            // Forwarded writeback satisfies exactly one pending write.
            if ((BYPASS != 0) && wb_fire && (wb_rd == addr)) begin
               data = wb_data;
               busy = (cnt_reg[addr] > CW'(1));
            end
            if (addr == '0) begin
               data = '0;
               busy = 1'b0;
            end
         end

         assign rd_data[gi*XLEN +: XLEN] = data;
         assign rd_busy[gi]              = busy;
      end
   endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb
//
// Directed scenarios followed by randomized traffic. The driver computes the
// expected outputs for each cycle from a plain array-based model of the
// register file and pushes them into a queue; a monitor on the falling edge
// pops each entry and compares it with what the design presents.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

   localparam int XLEN     = 32;
   localparam int NREGS    = 32;
   localparam int NRD      = 2;
   localparam int MAX_PEND = 3;
   localparam int BYPASS   = 1;
   localparam int AW       = $clog2(NREGS);

   logic                clk = 1'b0;
   logic                reset;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                issue_valid;
   logic [AW-1:0]       issue_rd;
   logic                issue_ready;
   logic                wb_valid;
   logic [AW-1:0]       wb_rd;
   logic [XLEN-1:0]     wb_data;
   logic                flush;
   logic                sb_err;
   logic [AW-1:0]       dbg_addr;
   logic [XLEN-1:0]     dbg_data;

   regfile_sb #(
      .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .MAX_PEND(MAX_PEND), .BYPASS(BYPASS)
   ) dut (
      .clk(clk), .reset(reset),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .flush(flush), .sb_err(sb_err),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   // Reference model: register values, pending counts, sticky error.
   int unsigned m_regs [NREGS];
   int          m_cnt  [NREGS];
   bit          m_err;

   typedef struct {
      int          id;
      logic [31:0] d0;
      logic [31:0] d1;
      logic        b0;
      logic        b1;
      logic        rdy;
      logic        err;
      logic [31:0] dbg;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   txn   = 0;

   function automatic void chk(string name, int id, logic [31:0] act, logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s txn=%0d got=%h expected=%h", name, id, act, req);
      end
   endfunction

   // Expected read result for address a under the current model state.
   function automatic void model_read(input int a, output logic [31:0] d, output logic b);
      if (a == 0) begin
         d = 0; b = 0;
      end else if (BYPASS != 0 && wb_valid && int'(wb_rd) == a) begin
         d = wb_data; b = (m_cnt[a] > 1);
      end else begin
         d = m_regs[a]; b = (m_cnt[a] != 0);
      end
   endfunction

   // Drive one cycle: apply inputs, queue expected outputs, then advance the
   // model across the rising edge.
   task automatic cycle(input bit rst, input bit iv, input int ird,
                        input bit wbv, input int wrd, input logic [31:0] wdat,
                        input bit fl, input int ra0, input int ra1, input int dbga);
      exp_t e;
      bit   rdy;
      bit   wfire;
      reset       = rst;
      issue_valid = iv;
      issue_rd    = AW'(ird);
      wb_valid    = wbv;
      wb_rd       = AW'(wrd);
      wb_data     = wdat;
      flush       = fl;
      rd_addr     = {AW'(ra1), AW'(ra0)};
      dbg_addr    = AW'(dbga);

      wfire = wbv && (wrd != 0);
      rdy   = !fl && (ird == 0 || m_cnt[ird] < MAX_PEND || (wfire && wrd == ird));
      e.id  = txn;
      model_read(ra0, e.d0, e.b0);
      model_read(ra1, e.d1, e.b1);
      e.rdy = rdy;
      e.err = m_err;
      e.dbg = m_regs[dbga];
      exp_q.push_back(e);
      $display("[TB] txn %0d rst=%0d iss=%0d->x%0d wb=%0d x%0d=%h fl=%0d rd x%0d x%0d",
               txn, rst, iv, ird, wbv, wrd, wdat, fl, ra0, ra1);
      txn++;

      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = 0; m_cnt[i] = 0;
         end
         m_err = 0;
      end else begin
         if (wfire) begin
            m_regs[wrd] = wdat;
            if (!fl && m_cnt[wrd] == 0) m_err = 1;
         end
         if (fl) begin
            for (int i = 0; i < NREGS; i++) m_cnt[i] = 0;
         end else begin
            int delta [NREGS];
            for (int i = 0; i < NREGS; i++) delta[i] = 0;
            if (iv && rdy && ird != 0) delta[ird] += 1;
            if (wfire) delta[wrd] -= 1;
            for (int i = 1; i < NREGS; i++) begin
               m_cnt[i] += delta[i];
               if (m_cnt[i] < 0) m_cnt[i] = 0;
            end
         end
      end
      #1;
   endtask

   task automatic rd(input int a0, input int a1);
      cycle(0, 0, 0, 0, 0, 0, 0, a0, a1, a0);
   endtask

   // Monitor: compare every queued expectation against the live outputs.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("rd_data0", e.id, rd_data[31:0], e.d0);
         chk("rd_data1", e.id, rd_data[63:32], e.d1);
         chk("rd_busy0", e.id, 32'(rd_busy[0]), 32'(e.b0));
         chk("rd_busy1", e.id, 32'(rd_busy[1]), 32'(e.b1));
         chk("issue_ready", e.id, 32'(issue_ready), 32'(e.rdy));
         chk("sb_err", e.id, 32'(sb_err), 32'(e.err));
         chk("dbg_data", e.id, dbg_data, e.dbg);
      end
   end

   initial begin
      for (int i = 0; i < NREGS; i++) begin
         m_regs[i] = 0; m_cnt[i] = 0;
      end
      m_err = 0;
      reset = 1; issue_valid = 0; issue_rd = 0; wb_valid = 0; wb_rd = 0;
      wb_data = 0; flush = 0; rd_addr = 0; dbg_addr = 0;
      @(posedge clk); #1;

      // Reset, then sweep every address on both ports.
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int a = 0; a < NREGS; a++) rd(a, NREGS - 1 - a);

      // Issue then bypassed writeback of x5.
      cycle(0, 1, 5, 0, 0, 0, 0, 5, 5, 5);
      rd(5, 5);
      cycle(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 5, 0, 5);
      rd(5, 0);

      // Saturate x7, then issue alongside a writeback, then drain.
      for (int k = 0; k < 3; k++) cycle(0, 1, 7, 0, 0, 0, 0, 7, 0, 7);
      cycle(0, 1, 7, 0, 0, 0, 0, 7, 0, 7);
      cycle(0, 1, 7, 1, 7, 32'h7000_0001, 0, 7, 0, 7);
      for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 7, 32'h7000_0010 + k, 0, 7, 7, 7);
      rd(7, 7);

      // x0 ignores writes and issues.
      cycle(0, 1, 0, 1, 0, 32'h1234, 0, 0, 0, 0);
      rd(0, 0);

      // Flush with an issue and a writeback to an idle register.
      cycle(0, 1, 3, 0, 0, 0, 0, 3, 4, 3);
      cycle(0, 1, 4, 0, 0, 0, 0, 3, 4, 4);
      cycle(0, 1, 6, 1, 9, 32'h55, 1, 3, 9, 9);
      rd(3, 4);
      rd(6, 9);

      // Stray writeback sets the sticky error; reset clears it.
      cycle(0, 0, 0, 1, 10, 32'hA, 0, 10, 0, 10);
      rd(10, 2);
      rd(2, 10);
      cycle(1, 1, 2, 0, 0, 0, 0, 2, 10, 2);
      rd(2, 10);

      // Randomized traffic over a small hot set to provoke hazards.
      for (int n = 0; n < 2000; n++) begin
         bit rst, iv, wbv, fl;
         int ird, wrd;
         rst = ($urandom_range(0, 99) == 0);
         fl  = ($urandom_range(0, 19) == 0);
         iv  = ($urandom_range(0, 2) != 0);
         wbv = ($urandom_range(0, 2) != 0);
         ird = $urandom_range(0, 7);
         wrd = $urandom_range(0, 7);
         // Mostly write back registers that are actually pending.
         if ($urandom_range(0, 9) < 8) begin
            for (int t = 0; t < 8; t++) begin
               int c;
               c = $urandom_range(1, 7);
               if (m_cnt[c] > 0) begin
                  wrd = c;
                  break;
               end
            end
         end
         cycle(rst, iv, ird, wbv, wrd, $urandom, fl,
               $urandom_range(0, 7), $urandom_range(0, NREGS - 1), $urandom_range(0, 7));
      end

      // Let the monitor drain, bounded.
      for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain pending=%0d expected=0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
